barrel_shift_sequencer: RTL
===========================

// Module: barrel_shift_sequencer
// PURPOSE
//  Upstream controller for the 4-bit barrel shifter. Accepts a shift request whose
//  total amount (0-15) can exceed the shifter's 2-bit S range. Splits it into
//  back-to-back steps of at most 3, drives D/S/dir each cycle and feeds Y back.
//  Returns the final word on a valid/ready output with a step count.
// PARAMETERS
//  WIDTH     4  data width; must match the shifter's D/Y width
//  AMT_W     4  width of requested total shift amount
//  STEP_MAX  3  largest per-step shift; equals the max value of the shifter's S
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      request present
//  in_ready   out  1      request accepted when in_valid & in_ready
//  in_data    in   WIDTH  word to shift
//  in_amt     in   AMT_W  total shift amount
//  in_dir     in   1      0 = left, 1 = right (same encoding as shifter dir)
//  sh_D       out  WIDTH  to shifter D
//  sh_S       out  2      to shifter S
//  sh_dir     out  1      to shifter dir
//  sh_Y       in   WIDTH  from shifter Y (combinational, same cycle)
//  out_valid  out  1      result present
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_data   out  WIDTH  shifted result
//  out_steps  out  3      number of shifter steps used (0-5)
// BEHAVIOUR
//  One clock (clk); synchronous active-high reset (rst). All state flops reset on rst.
//  Reset: state=IDLE, acc=0, rem=0, dir=0, steps=0; out_valid=0, out_data=0,
//   out_steps=0, sh_D=0, sh_S=0, sh_dir=0. in_ready=0 while rst is high.
//  FSM states: IDLE, STEP, DONE.
//  IDLE: in_ready=1. On accept, latch acc=in_data, rem=in_amt, dir=in_dir, steps=0.
//   Next state is DONE if in_amt==0, otherwise STEP.
//  STEP: in_ready=0. Drive sh_D=acc, sh_dir=dir, sh_S=min(rem,STEP_MAX).
//   At the clock edge: acc<=sh_Y, rem<=rem-sh_S, steps<=steps+1.
//   Go to DONE when rem-sh_S==0; otherwise stay in STEP.
//  DONE: out_valid=1, out_data=acc, out_steps=steps.
//   On out_ready go to IDLE.
//   While out_ready is low, out_data and out_steps hold stable.
//  In IDLE and DONE: sh_S=0, sh_D=acc, sh_dir=dir (shifter passes acc unchanged).
//  Latency from the accept edge to out_valid high:
//   1 cycle for amt=0; 1+ceil(amt/3) cycles otherwise.
//   Max is 6 cycles (amt=15, 5 steps).
//  Throughput: one request in flight. in_ready is low in STEP and DONE.
//   in_valid in those states is ignored; the requester holds it.
//  Amounts >= WIDTH are not short-circuited. All steps execute and zeros shift in.
//  There is no rotate and no sign fill; the shifter zero-fills.
//  rem never underflows because sh_S <= rem by construction.
//  steps saturates naturally at 5 for AMT_W=4.
//  rst mid-operation (any state): the request is dropped and nothing is emitted.
//   IDLE applies the cycle after rst falls.
// TESTING
//  1. in_data=1011, amt=0, dir=0 accepted
//     -> next cycle out_valid=1, out_data=1011, out_steps=0.
//  2. in_data=0001, amt=2, dir=0
//     -> one STEP with sh_S=2; out_data=0100, out_steps=1.
//  3. in_data=0001, amt=4, dir=0
//     -> sh_S sequence 3,1; acc 1000 then 0000; out_steps=2.
//  4. in_data=1111, amt=15, dir=1
//     -> sh_S=3 five times; out_data=0000, out_steps=5;
//        out_valid 6 cycles after accept.
//  5. out_ready low for 3 cycles in DONE
//     -> out_valid, out_data, out_steps stable and in_ready=0;
//        a new in_valid is not accepted; accept occurs 1 cycle after out_ready.
//  6. amt=9 with rst asserted during the 2nd STEP
//     -> next cycle out_valid=0, sh_S=0; after rst falls in_ready=1 and no result appears.

Source files
------------

// File: rtl/barrel_shift_sequencer_if.sv
// Request, result and shifter-link signals for barrel_shift_sequencer.
// slave is the sequencer side, master is the requester/shifter side.
interface barrel_shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic [WIDTH-1:0] sh_D;
    logic [1:0]       sh_S;
    logic             sh_dir;
    logic [WIDTH-1:0] sh_Y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_steps;

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, sh_Y, out_ready,
        output in_ready, sh_D, sh_S, sh_dir, out_valid, out_data, out_steps
    );

    modport master (
        output in_valid, in_data, in_amt, in_dir, sh_Y, out_ready,
        input  in_ready, sh_D, sh_S, sh_dir, out_valid, out_data, out_steps
    );
endinterface

// File: rtl/barrel_shift_sequencer.sv
// Splits a 0-15 shift into steps of at most 3 on an external 4-bit
// barrel shifter, feeding Y back, and returns the word with a step count.
module barrel_shift_sequencer #(
    parameter int WIDTH    = 4,
    parameter int AMT_W    = 4,
    parameter int STEP_MAX = 3
) (
    input logic clk,
    input logic rst,
    barrel_shift_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] STEP = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] rem;
    logic             dir;
    logic [2:0]       steps;
    logic [AMT_W-1:0] step_amt;
    logic [AMT_W-1:0] rem_next;

    // Per-step amount is the remainder clipped to the shifter's S range
    always_comb begin
        step_amt = (rem > STEP_LIM) ? STEP_LIM : rem;
        rem_next = rem - step_amt;
    end

    // Shifter link, handshakes and result are all decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.sh_D      = acc;
        bus.sh_dir    = dir;
        bus.sh_S      = (state == STEP) ? step_amt[1:0] : 2'd0;
        bus.out_valid = (state == DONE);
        bus.out_data  = (state == DONE) ? acc : '0;
        bus.out_steps = (state == DONE) ? steps : 3'd0;
    end

    // Request capture, step iteration and result hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            dir   <= 1'b0;
            steps <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc   <= bus.in_data;
                        rem   <= bus.in_amt;
                        dir   <= bus.in_dir;
                        steps <= 3'd0;
                        state <= (bus.in_amt == '0) ? DONE : STEP;
                    end
                end
                STEP: begin
                    acc   <= bus.sh_Y;
                    rem   <= rem_next;
                    steps <= steps + 3'd1;
                    if (rem_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
